mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit with HI/LO registers for the MIPS datapath.
//   Sits directly downstream of the register file: its operands come from
//   readData1 (rs) and readData2 (rt).
//   Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds results in
//   HI/LO for MFHI/MFLO.
//   Asserts busy so the control path can stall dependent HI/LO reads.
// PARAMETERS
//   DATA_WIDTH  32  operand width; HI and LO are each DATA_WIDTH bits
// PORTS
//   clk           in   1           clock, rising edge
//   reset         in   1           asynchronous, active-low
//   start         in   1           launch op; sampled only in IDLE
//   op            in   2           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data       in   DATA_WIDTH  multiplicand / dividend (readData1)
//   rt_data       in   DATA_WIDTH  multiplier / divisor (readData2)
//   mthi          in   1           write rs_data to HI; IDLE only
//   mtlo          in   1           write rs_data to LO; IDLE only
//   hi            out  DATA_WIDTH  HI register (product[2W-1:W] / remainder)
//   lo            out  DATA_WIDTH  LO register (product[W-1:0] / quotient)
//   busy          out  1           high while an op is in flight
//   done          out  1           one-cycle pulse when HI/LO take a result
//   div_by_zero   out  1           one-cycle pulse with done, DIV/DIVU by 0
// BEHAVIOUR
//   Reset: state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter=0.
//   Reset is effective at any time, including mid-operation; the
//   in-flight op is discarded.
//   States: IDLE -> CALC -> FIX -> IDLE.
//   - IDLE, start=1 (edge E0): latch op, |rs|, |rt| and sign flags.
//     Signed ops only take absolute values. Go to CALC, busy=1, count=0.
//   - DIV/DIVU with rt_data==0 at E0: go directly to FIX with dbz flag set.
//   - CALC: one shift-add (mult) or restoring shift-subtract (div) step per
//     edge, for DATA_WIDTH edges (E1..EW), then go to FIX.
//   - FIX (edge EW+1): apply sign correction and write hi/lo.
//     done=1 for one cycle, busy=0, return to IDLE.
//     Latency: done and new hi/lo are visible after edge E0+DATA_WIDTH+1.
//     For W=32 this is 33 edges after start.
//   - Div-by-zero: FIX on E1; done=1, div_by_zero=1, hi/lo unchanged.
//   Arithmetic:
//   - MULTU: {hi,lo} = rs*rt unsigned, 2W-bit.
//   - MULT: product negated iff operand signs differ.
//   - DIVU: lo = rs/rt, hi = rs%rt.
//   - DIV: quotient truncates toward zero and is negated iff signs differ.
//     Remainder takes the sign of the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//   Boundaries:
//   - start while busy: ignored, no queueing.
//   - mthi/mtlo while busy: ignored.
//   - start together with mthi/mtlo in IDLE: start wins, the move is
//     dropped.
//   - mthi and mtlo together: both written from rs_data.
//   - Operand inputs may change after E0; the latched copies are used.
//   - hi/lo hold their value between ops; they never glitch mid-CALC.
// TESTING
//   1 MULTU rs=FFFFFFFF rt=FFFFFFFF -> hi=FFFFFFFE lo=00000001.
//     done 33 edges after start; busy high 33 cycles.
//   2 MULT rs=FFFFFFFD (-3) rt=00000007 -> hi=FFFFFFFF lo=FFFFFFEB (-21).
//   3 DIV rs=FFFFFFF9 (-7) rt=00000002 -> lo=FFFFFFFD (-3) hi=FFFFFFFF (-1).
//     DIVU 100/7 -> lo=0000000E hi=00000002.
//   4 DIVU rs=64 rt=0 with hi=A, lo=B -> done and div_by_zero on edge 2.
//     hi=A, lo=B unchanged. Also DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//   5 During CALC: pulse start (new op), mthi=1 -> both ignored.
//     Original result lands at edge 33. In IDLE, mtlo rs=1234 -> lo=1234
//     next edge, done stays 0.
//   6 Assert reset at edge 10 of a MULT -> hi=lo=0, busy=0 immediately.
//     After release, a new MULTU 3*5 -> lo=0000000F hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  mthi,
  input  logic                  mtlo,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [W-1:0] abs_val(input logic [W-1:0] x, input logic is_signed);
    if (is_signed && x[W-1]) begin
      abs_val = ~x + {{(W-1){1'b0}}, 1'b1};
    end else begin
      abs_val = x;
    end
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;        // running upper product / partial remainder
  logic [W-1:0]  b_q, b_d;        // multiplier being consumed / quotient being built
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] count_q, count_d;
  logic          is_div_q, is_div_d;
  logic          neg_q, neg_d;
  logic          rneg_q, rneg_d;
  logic          dbz_q, dbz_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          div_by_zero_q, div_by_zero_d;

  logic           signed_op;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] prod_mag;
  logic [2*W-1:0] prod_neg;
  logic [W-1:0]   quo_neg;
  logic [W-1:0]   rem_neg;

  assign signed_op = ~op[0];
  assign mul_sum   = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
  assign div_shift = {a_q, b_q[W-1]};
  assign div_ge    = (div_shift >= {1'b0, m_q});
  // The partial remainder is always below the divisor, so W bits hold the difference.
  assign div_diff  = div_shift[W-1:0] - m_q;
  assign prod_mag  = {a_q, b_q};
  assign prod_neg  = ~prod_mag + {{(2*W-1){1'b0}}, 1'b1};
  assign quo_neg   = ~b_q + {{(W-1){1'b0}}, 1'b1};
  assign rem_neg   = ~a_q + {{(W-1){1'b0}}, 1'b1};

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      a_q           <= {W{1'b0}};
      b_q           <= {W{1'b0}};
      m_q           <= {W{1'b0}};
      count_q       <= {CW{1'b0}};
      is_div_q      <= 1'b0;
      neg_q         <= 1'b0;
      rneg_q        <= 1'b0;
      dbz_q         <= 1'b0;
      hi_q          <= {W{1'b0}};
      lo_q          <= {W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      m_q           <= m_d;
      count_q       <= count_d;
      is_div_q      <= is_div_d;
      neg_q         <= neg_d;
      rneg_q        <= rneg_d;
      dbz_q         <= dbz_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op[1] && (rt_data == {W{1'b0}})) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (count_q == CW'(W - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output register updates.
  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    m_d           = m_q;
    count_d       = count_q;
    is_div_d      = is_div_q;
    neg_d         = neg_q;
    rneg_d        = rneg_q;
    dbz_d         = dbz_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;
    div_by_zero_d = 1'b0;
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          a_d      = {W{1'b0}};
          b_d      = abs_val(rs_data, signed_op);
          m_d      = abs_val(rt_data, signed_op);
          neg_d    = signed_op & (rs_data[W-1] ^ rt_data[W-1]);
          rneg_d   = signed_op & rs_data[W-1];
          dbz_d    = op[1] & (rt_data == {W{1'b0}});
          count_d  = {CW{1'b0}};
        end else begin
          if (mthi) begin
            hi_d = rs_data;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo) begin
            lo_d = rs_data;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_CALC: begin
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (is_div_q) begin
          if (div_ge) begin
            a_d = div_diff;
            b_d = {b_q[W-2:0], 1'b1};
          end else begin
            a_d = div_shift[W-1:0];
            b_d = {b_q[W-2:0], 1'b0};
          end
        end else begin
          a_d = mul_sum[W:1];
          b_d = {mul_sum[0], b_q[W-1:1]};
        end
      end
      S_FIX: begin
        done_d  = 1'b1;
        count_d = {CW{1'b0}};
        if (dbz_q) begin
          div_by_zero_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_q  ? quo_neg : b_q;
          hi_d = rneg_q ? rem_neg : a_q;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod_mag;
        end
      end
      default: begin
        count_d = {CW{1'b0}};
      end
    endcase
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int vectors;
  int miscompares;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: what HI/LO should hold after the op, from MIPS arithmetic rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl, output logic dbz);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    nh = m_hi;
    nl = m_lo;
    dbz = 1'b0;
    case (o)
      2'd0: begin sp = sa * sb; nh = sp[63:32]; nl = sp[31:0]; end
      2'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; end
      2'd2: begin
        if (b == 32'd0) dbz = 1'b1;
        else begin sq = sa / sb; sr = sa % sb; nl = sq[31:0]; nh = sr[31:0]; end
      end
      default: begin
        if (b == 32'd0) dbz = 1'b1;
        else begin nl = 32'(ua / ub); nh = 32'(ua % ub); end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit disturb, input bit with_move);
    logic [31:0] eh, el, pre_hi, pre_lo;
    logic        edbz;
    int          n;
    bit          busy_ok, stable_ok;
    model(o, a, b, eh, el, edbz);
    pre_hi = hi;
    pre_lo = lo;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    mthi = with_move; mtlo = with_move;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
    n = 0; busy_ok = 1'b1; stable_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hi !== pre_hi || lo !== pre_lo) stable_ok = 1'b0;
      if (disturb && n == 5) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'($urandom);
      end else if (disturb && n == 6) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("latency", 64'(n), edbz ? 64'd1 : 64'd33);
    chk("busy_in_flight", 64'(busy_ok), 64'd1);
    chk("hilo_stable", 64'(stable_ok), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    chk("div_by_zero", 64'(div_by_zero), 64'(edbz));
    m_hi = eh;
    m_lo = el;
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    chk("no_queue", 64'(busy), 64'd0);
  endtask

  task automatic do_move(input bit h, input bit l, input logic [31:0] v);
    rs_data = v; mthi = h; mtlo = l;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    chk("move_hi", 64'(hi), 64'(m_hi));
    chk("move_lo", 64'(lo), 64'(m_lo));
    chk("move_done", 64'(done), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 32'd0;
      1:       pick = 32'hFFFF_FFFF;
      2:       pick = 32'h8000_0000;
      3:       pick = 32'($urandom_range(0, 15));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b0; start = 1'b0; op = 2'd0; rs_data = 32'd0; rt_data = 32'd0;
    mthi = 1'b0; mtlo = 1'b0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b1;
    tick();

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    do_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    do_move(1'b1, 1'b0, 32'h0000_000A);
    do_move(1'b0, 1'b1, 32'h0000_000B);
    do_op(2'd3, 32'd64, 32'd0, 1'b0, 1'b0);
    do_op(2'd2, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(2'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1, 1'b0);
    do_move(1'b0, 1'b1, 32'h0000_1234);
    do_move(1'b1, 1'b1, 32'hCAFE_F00D);

    // Reset mid-MULT discards the op and clears HI/LO immediately.
    op = 2'd0; rs_data = 32'h1234_5678; rt_data = 32'h8765_4321; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    #1;
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    #2;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    do_op(2'd1, 32'd3, 32'd5, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_move(1'($urandom), 1'($urandom), $urandom);
      end else begin
        do_op(2'($urandom), pick(), pick(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
